// File: rtl/cache_bus_ctrl.sv
// Purpose  : two-core coherent bus arbiter between I/D caches and one memory port (MSI snoop, cache-to-cache).
// Latency  : one IDLE arbitration cycle per grant, then one state per memory word; ramstate ACCESS completes a word.
// Backpress: BUSY, FREE and ERROR on ramstate hold state and outputs (ERROR retries the word); ungranted cores see wait=1.
//
// Ports:
//   CLK, nRST               clock; synchronous active-high reset
//   iREN/iaddr -> iwait/iload                     per-core instruction fetch
//   dREN/dWEN/daddr/dstore -> dwait/dload         per-core data read / write-back
//   ccwrite -> ccwait/ccinv/ccsnoopaddr           per-core coherence handshake
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate   memory port

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module cache_bus_ctrl
    import cpu_types_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic [1:0]      iREN,
    input  word_t [1:0]     iaddr,
    output logic [1:0]      iwait,
    output word_t [1:0]     iload,
    input  logic [1:0]      dREN,
    input  logic [1:0]      dWEN,
    input  word_t [1:0]     daddr,
    input  word_t [1:0]     dstore,
    output logic [1:0]      dwait,
    output word_t [1:0]     dload,
    input  logic [1:0]      ccwrite,
    output logic [1:0]      ccwait,
    output logic [1:0]      ccinv,
    output word_t [1:0]     ccsnoopaddr,
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    typedef enum logic [3:0] {
        IDLE, WB, SNOOP, C2C0, C2C1, MEM0, MEM1, INV, IFETCH
    } state_t;

    state_t state, next_state;
    state_t arb_state;
    logic   arb_core;
    logic   ptr;        // round-robin pointer, shared by all request classes
    logic   req;        // granted core
    logic   snp;        // the other core (snoop target for data requests)
    logic   access;
    logic [1:0] inv_only;

    assign access   = (ramstate == ACCESS);
    // ccwrite without a data request is a write-hit upgrade (invalidate only)
    assign inv_only = ccwrite & ~dREN & ~dWEN;

    // Within a class the pointer core wins when it requests, else the other one.
    function automatic logic pick(input logic [1:0] m, input logic p);
        return m[p] ? p : ~p;
    endfunction

    // Class priority: write-back, read, invalidate, instruction fetch.
    always_comb begin
        arb_state = IDLE;
        arb_core  = 1'b0;
        if (|dWEN) begin
            arb_state = WB;
            arb_core  = pick(dWEN, ptr);
        end else if (|dREN) begin
            arb_state = SNOOP;
            arb_core  = pick(dREN, ptr);
        end else if (|inv_only) begin
            arb_state = INV;
            arb_core  = pick(inv_only, ptr);
        end else if (|iREN) begin
            arb_state = IFETCH;
            arb_core  = pick(iREN, ptr);
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state <= IDLE;
            ptr   <= 1'b0;
            req   <= 1'b0;
            snp   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE) begin
                req <= arb_core;
                snp <= ~arb_core;
            end
            // A grant is complete whenever a transaction returns to IDLE.
            if (state != IDLE && next_state == IDLE)
                ptr <= ~ptr;
        end
    end

    // Outputs are forced to their idle values while reset is asserted so an
    // aborted transaction issues no memory write in the reset cycle.
    always_comb begin
        next_state  = state;
        iwait       = 2'b11;
        dwait       = 2'b11;
        iload       = '0;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (!nRST) begin
            case (state)
                IDLE: next_state = arb_state;
                WB: begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[req];
                    ramstore = dstore[req];
                    if (access) begin
                        dwait[req] = 1'b0;
                        next_state = IDLE;
                    end
                end
                SNOOP: begin
                    ccwait[snp]      = 1'b1;
                    ccsnoopaddr[snp] = daddr[req];
                    ccinv[snp]       = ccwrite[req];
                    next_state       = ccwrite[snp] ? C2C0 : MEM0;
                end
                C2C0, C2C1: begin
                    // Modified line: forward to requester and write back to memory at once.
                    ccwait[snp]      = 1'b1;
                    ccsnoopaddr[snp] = daddr[req];
                    dload[req]       = dstore[snp];
                    ramWEN           = 1'b1;
                    ramaddr          = daddr[snp];
                    ramstore         = dstore[snp];
                    if (access) begin
                        dwait[req] = 1'b0;
                        dwait[snp] = 1'b0;
                        next_state = (state == C2C0) ? C2C1 : IDLE;
                    end
                end
                MEM0, MEM1: begin
                    ccwait[snp]      = 1'b1;
                    ccsnoopaddr[snp] = daddr[req];
                    ramREN           = 1'b1;
                    ramaddr          = daddr[req];
                    dload[req]       = ramload;
                    if (access) begin
                        dwait[req] = 1'b0;
                        next_state = (state == MEM0) ? MEM1 : IDLE;
                    end
                end
                INV: begin
                    ccwait[snp]      = 1'b1;
                    ccinv[snp]       = 1'b1;
                    ccsnoopaddr[snp] = daddr[req];
                    dwait[req]       = 1'b0;
                    next_state       = IDLE;
                end
                IFETCH: begin
                    ramREN     = 1'b1;
                    ramaddr    = iaddr[req];
                    iload[req] = ramload;
                    if (access) begin
                        iwait[req] = 1'b0;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end else begin
            next_state = IDLE;
        end
    end

endmodule

// File: doc/cache_bus_ctrl.md
CACHE_BUS_CTRL -- requirements
Module: cache_bus_ctrl

Interface
REQ-001 Parameters: none; two cores fixed; word_t and ramstate_t (FREE, BUSY, ACCESS, ERROR) from cpu_types_pkg.
REQ-002 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-003 nRST  in  1  reset; one clock, synchronous, active-high (1 = reset).
REQ-004 iREN  in  [1:0]  per-core instruction fetch request.
REQ-005 iaddr  in  2x32  per-core fetch address.
REQ-006 iwait  out  [1:0]  per-core fetch stall; 0 = iload valid this cycle.
REQ-007 iload  out  2x32  per-core fetch data.
REQ-008 dREN, dWEN  in  [1:0] each  per-core data read and data write-back request.
REQ-009 daddr, dstore  in  2x32 each  per-core data address and store word.
REQ-010 dwait  out  [1:0]  per-core data stall; 0 = word transferred this cycle.
REQ-011 dload  out  2x32  per-core data read word.
REQ-012 ccwrite  in  [1:0]  per-core: with dREN = read-exclusive intent; alone = write-hit invalidate request; during a snoop = "I hold the line in M".
REQ-013 ccwait  out  [1:0]  per-core: you are being snooped; hold in snoop handling.
REQ-014 ccinv  out  [1:0]  per-core: invalidate the snooped line.
REQ-015 ccsnoopaddr  out  2x32  per-core snoop address.
REQ-016 ramREN, ramWEN  out  1 each  memory read and write strobes; never both 1.
REQ-017 ramaddr, ramstore  out  32 each  memory address and write data.
REQ-018 ramload  in  32  memory read data.
REQ-019 ramstate  in  ramstate_t  memory status; ACCESS = current word completes this cycle.

Function
REQ-020 States: IDLE, WB, SNOOP, C2C0, C2C1, MEM0, MEM1, INV, IFETCH.
REQ-021 IDLE: select one request by class priority: dWEN, then dREN, then ccwrite-only, then iREN.
REQ-022 Within a class, a round-robin pointer picks the core; it toggles after every completed grant and is 0 after reset.
REQ-023 The granted core index (req) and, for data requests, the other core (snp) are latched at the IDLE exit.
REQ-024 WB: ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req]; on ACCESS: dwait[req]=0, go to IDLE. Each write-back word is a separate grant.
REQ-025 SNOOP: hold for exactly 1 cycle; ccwait[snp]=1, ccsnoopaddr[snp]=daddr[req], ccinv[snp]=ccwrite[req]; if ccwrite[snp]=1, go to C2C0, else go to MEM0.
REQ-026 C2C0/C2C1: dload[req]=dstore[snp]; ramWEN=1, ramaddr=daddr[snp], ramstore=dstore[snp].
REQ-027 C2C0/C2C1: on ACCESS, dwait[req]=0 and dwait[snp]=0; C2C0 goes to C2C1, C2C1 goes to IDLE.
REQ-028 MEM0/MEM1: ramREN=1, ramaddr=daddr[req], dload[req]=ramload; on ACCESS, dwait[req]=0; MEM0 goes to MEM1, MEM1 goes to IDLE.
REQ-029 ccwait[snp]=1 and ccsnoopaddr[snp] held from SNOOP through the last data word; ccinv[snp] is asserted only in SNOOP.
REQ-030 INV: hold for 1 cycle; ccwait[snp]=1, ccinv[snp]=1, ccsnoopaddr[snp]=daddr[req], dwait[req]=0; go to IDLE.
REQ-031 IFETCH: ramREN=1, ramaddr=iaddr[req], iload[req]=ramload; on ACCESS, iwait[req]=0, go to IDLE.
REQ-032 In IDLE, all waits=1, cc outputs=0, ram strobes=0; an ungranted requester always sees wait=1.
REQ-033 ramstate BUSY/FREE keeps the state and outputs unchanged.
REQ-034 ramstate ERROR is treated as BUSY; the word is retried.
REQ-035 Request dropped mid-grant (by abort or reset): the transaction still completes to IDLE; no spurious wait=0 is driven to other cores.
REQ-036 Simultaneous same-class requests from both cores: the pointer core wins; the loser waits, with no starvation beyond one grant.
REQ-037 Snooping core asserts dWEN during SNOOP: the request is ignored until IDLE.
REQ-038 Default outputs: iload/dload=0, ramaddr=0, ramstore=0, ccsnoopaddr=0 when not driven.

Reset
REQ-039 nRST=1 at posedge: state=IDLE, pointer=0, req/snp=0; iwait=dwait=2'b11, ccwait=ccinv=0, ramREN=ramWEN=0; all buses 0.
REQ-040 nRST=1 mid-transaction aborts to IDLE with no memory write issued that cycle.

Verification
REQ-041 Core0 iREN, iaddr=0x40, ramstate ACCESS after 2 BUSY cycles, ramload=0x1234 -> iwait[0]=0 with iload[0]=0x1234 on cycle 3 only.
REQ-042 Both dREN same cycle, pointer=0 -> core0 snoop of core1 (ccwait[1]=1), two MEM words, then core1 is served; pointer ends at 0.
REQ-043 Core1 dREN+ccwrite at 0x80, core0 replies ccwrite=1 with dstore=0xAA,0xBB -> ccinv[0]=1 in SNOOP; dload[1]=0xAA then 0xBB; ram writes of 0xAA,0xBB to daddr[0].
REQ-044 Core0 ccwrite alone at 0x100 -> 1 INV cycle: ccinv[1]=1, ccsnoopaddr[1]=0x100, dwait[0]=0; no ram strobe.
REQ-045 dWEN[1] and iREN[0] together -> WB first (ramWEN, ramstore=dstore[1]), then IFETCH.
REQ-046 nRST=1 during C2C0 -> next cycle in IDLE, all waits=1, ramWEN=0.
